// File: rtl/sram_data_encoder.sv
// Packs encoded pixel colors into 16-bit SRAM words, pixel 0 in the low field.
// Issues sequential word writes. Optional partial-word flush: SRAM_DATA_ENCODER_FLUSH_EN.
module sram_data_encoder #(
  parameter int PIXEL_PER_ADDR = 4,
  parameter int COLOR_WIDTH    = 4,
  parameter int COUNTER_WIDTH  = 2,
  parameter int ADDR_WIDTH     = 20,
  parameter int BASE_ADDR      = 0,
  parameter int FRAME_WORDS    = 76800
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [COLOR_WIDTH-1:0] i_color,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_frame_start,
  input  logic                   i_flush,
  output logic                   o_wr_req,
  output logic [ADDR_WIDTH-1:0]  o_sram_addr,
  output logic [15:0]            o_sram_data,
  input  logic                   i_wr_gnt,
  output logic                   o_frame_done
);

  localparam logic [COUNTER_WIDTH-1:0] LAST_CNT   = COUNTER_WIDTH'(PIXEL_PER_ADDR - 1);
  localparam logic [ADDR_WIDTH-1:0]    FIRST_ADDR = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0]    LAST_ADDR  = ADDR_WIDTH'(BASE_ADDR + FRAME_WORDS - 1);

  logic [15:0]              pack_q;
  logic [15:0]              pack_next;
  logic [COUNTER_WIDTH-1:0] cnt_q;
  logic [COUNTER_WIDTH-1:0] cnt_base;
  logic                     out_valid_q;
  logic [15:0]              data_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic                     frame_done_q;
  logic                     accept;
  logic                     grant;
  logic                     complete;
  logic                     flush_go;
  logic                     flush_block;

  assign accept = i_valid && o_ready;
  assign grant  = out_valid_q && i_wr_gnt;

  // A frame start restarts packing, so a same-cycle pixel lands in field 0.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    cnt_base  = i_frame_start ? '0 : cnt_q;
    pack_next = i_frame_start ? '0 : pack_q;
    for (int i = 0; i < PIXEL_PER_ADDR; i++) begin
      if (accept && cnt_base == COUNTER_WIDTH'(i))
        pack_next[i*COLOR_WIDTH +: COLOR_WIDTH] = i_color;
    end
  end

  assign complete = accept && (cnt_base == LAST_CNT);

`ifdef SRAM_DATA_ENCODER_FLUSH_EN
  logic flush_pend_q;
  logic flush_req;

  assign flush_req   = i_flush && !i_frame_start && !complete && (cnt_base != '0 || accept);
  assign flush_go    = !i_frame_start && (flush_pend_q || flush_req) && (!out_valid_q || i_wr_gnt);
  assign flush_block = flush_pend_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)                          flush_pend_q <= 1'b0;
    else if (i_frame_start || flush_go) flush_pend_q <= 1'b0;
    else if (flush_req)                 flush_pend_q <= 1'b1;
  end
`else
  logic unused_flush;
  assign unused_flush = i_flush;
  assign flush_go     = 1'b0;
  assign flush_block  = 1'b0;
`endif

  // Registers only: a grant in this cycle never raises o_ready combinationally.
  assign o_ready = !((cnt_q == LAST_CNT) && out_valid_q) && !flush_block;

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      pack_q       <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      data_q       <= '0;
      addr_q       <= FIRST_ADDR;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (i_frame_start) begin
        addr_q      <= FIRST_ADDR;
        out_valid_q <= 1'b0;
        pack_q      <= pack_next;
        cnt_q       <= accept ? COUNTER_WIDTH'(1) : '0;
      end else begin
        if (grant) begin
          addr_q       <= (addr_q == LAST_ADDR) ? FIRST_ADDR : addr_q + ADDR_WIDTH'(1);
          frame_done_q <= (addr_q == LAST_ADDR);
        end
        if (complete || flush_go) begin
          out_valid_q <= 1'b1;
          data_q      <= pack_next;
          pack_q      <= '0;
          cnt_q       <= '0;
        end else begin
          if (grant)  out_valid_q <= 1'b0;
          if (accept) cnt_q <= cnt_q + COUNTER_WIDTH'(1);
          pack_q <= pack_next;
        end
      end
    end
  end

  assign o_wr_req     = out_valid_q;
  assign o_sram_addr  = addr_q;
  assign o_sram_data  = data_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_sram_data_encoder.sv
// Self-checking bench for sram_data_encoder: directed scenarios plus random traffic
// against a word-level reference model. A second instance uses a 2-word frame at base 16.
module tb_sram_data_encoder;

  localparam int PPA  = 4;
  localparam int CW   = 4;
  localparam int BASE = 0;
  localparam int FW   = 76800;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0, i_frame_start = 1'b0, i_flush = 1'b0, i_wr_gnt = 1'b0;
  logic [3:0]  i_color = '0;
  logic        o_ready, o_wr_req, o_frame_done;
  logic [19:0] o_sram_addr;
  logic [15:0] o_sram_data;
  logic        w_ready, w_wr_req, w_frame_done;
  logic [19:0] w_sram_addr;
  logic [15:0] w_sram_data;

  int errors = 0;
  int checks = 0;

  sram_data_encoder dut (
    .i_clk(clk), .i_rst(i_rst), .i_color(i_color), .i_valid(i_valid), .o_ready(o_ready),
    .i_frame_start(i_frame_start), .i_flush(i_flush), .o_wr_req(o_wr_req),
    .o_sram_addr(o_sram_addr), .o_sram_data(o_sram_data), .i_wr_gnt(i_wr_gnt),
    .o_frame_done(o_frame_done)
  );

  sram_data_encoder #(.BASE_ADDR(16), .FRAME_WORDS(2)) dut_wrap (
    .i_clk(clk), .i_rst(i_rst), .i_color(i_color), .i_valid(i_valid), .o_ready(w_ready),
    .i_frame_start(i_frame_start), .i_flush(i_flush), .o_wr_req(w_wr_req),
    .o_sram_addr(w_sram_addr), .o_sram_data(w_sram_data), .i_wr_gnt(i_wr_gnt),
    .o_frame_done(w_frame_done)
  );

  // Reference model: pixels collected into a word by arithmetic, one pending write slot.
  int          m_cnt;
  logic [15:0] m_pack, m_data;
  bit          m_pend, m_fd, m_flp;
  int          m_addr;

  function automatic bit m_ready();
    return !(m_cnt == PPA - 1 && m_pend) && !m_flp;
  endfunction

  task automatic m_reset();
    m_cnt = 0; m_pack = '0; m_data = '0; m_pend = 0; m_fd = 0; m_flp = 0; m_addr = BASE;
  endtask

  task automatic m_update(input bit v, input logic [3:0] c, input bit g, input bit fs, input bit fl);
    bit acc, gr, nfd;
    acc = v && m_ready();
    gr  = m_pend && g;
    nfd = 0;
    if (fs) begin
      m_addr = BASE; m_pend = 0; m_flp = 0;
      m_pack = acc ? 16'(c) : 16'h0;
      m_cnt  = acc ? 1 : 0;
    end else begin
      if (acc) begin
        m_pack = m_pack + (16'(c) << (CW * m_cnt));
        m_cnt++;
      end
      if (gr) begin
        if (m_addr == BASE + FW - 1) begin m_addr = BASE; nfd = 1; end
        else m_addr++;
        m_pend = 0;
      end
      if (m_cnt == PPA) begin
        m_pend = 1; m_data = m_pack; m_pack = '0; m_cnt = 0;
      end else begin
`ifdef SRAM_DATA_ENCODER_FLUSH_EN
        if (fl && m_cnt > 0) m_flp = 1;
        if (m_flp && !m_pend) begin
          m_pend = 1; m_data = m_pack; m_pack = '0; m_cnt = 0; m_flp = 0;
        end
`else
        if (fl) m_flp = 0;  // flush has no effect in this build
`endif
      end
    end
    m_fd = nfd;
  endtask

  task automatic step(input bit v, input logic [3:0] c, input bit g, input bit fs, input bit fl);
    i_valid = v; i_color = c; i_wr_gnt = g; i_frame_start = fs; i_flush = fl;
    m_update(v, c, g, fs, fl);
    @(posedge clk); #1;
    i_valid = 0; i_wr_gnt = 0; i_frame_start = 0; i_flush = 0;
  endtask

  task automatic do_reset();
    i_rst = 1; i_valid = 0; i_wr_gnt = 0; i_frame_start = 0; i_flush = 0;
    @(posedge clk); #1;
    i_rst = 0;
    m_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    checks++; if (o_wr_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", o_wr_req); end
    checks++; if (o_sram_addr !== 20'd0) begin errors++; $display("FAIL reset_addr: got %0h want 0", o_sram_addr); end
    checks++; if (o_sram_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", o_sram_data); end
    checks++; if (o_frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", o_frame_done); end
    checks++; if (w_sram_addr !== 20'd16) begin errors++; $display("FAIL reset_wrap_addr: got %0d want 16", w_sram_addr); end
  endtask

  task automatic test_basic_pack();
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, 4'(i), 1, 0, 0);
    checks++; if (o_wr_req !== 1'b1) begin errors++; $display("FAIL basic_req0: got %b want 1", o_wr_req); end
    checks++; if (o_sram_data !== 16'h4321) begin errors++; $display("FAIL basic_data0: got %h want 4321", o_sram_data); end
    checks++; if (o_sram_addr !== 20'd0) begin errors++; $display("FAIL basic_addr0: got %0d want 0", o_sram_addr); end
    for (int i = 5; i <= 8; i++) begin
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1 before pixel %0d", o_ready, i); end
      step(1, 4'(i), 1, 0, 0);
    end
    checks++; if (o_wr_req !== 1'b1) begin errors++; $display("FAIL basic_req1: got %b want 1", o_wr_req); end
    checks++; if (o_sram_data !== 16'h8765) begin errors++; $display("FAIL basic_data1: got %h want 8765", o_sram_data); end
    checks++; if (o_sram_addr !== 20'd1) begin errors++; $display("FAIL basic_addr1: got %0d want 1", o_sram_addr); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 1; i <= 7; i++) step(1, 4'(i), 0, 0, 0);
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop: got %b want 0", o_ready); end
    step(1, 4'd8, 0, 0, 0);
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_hold: got %b want 0", o_ready); end
    checks++; if (o_sram_data !== 16'h4321) begin errors++; $display("FAIL bp_data_hold: got %h want 4321", o_sram_data); end
    checks++; if (o_sram_addr !== 20'd0) begin errors++; $display("FAIL bp_addr_hold: got %0d want 0", o_sram_addr); end
    step(1, 4'd8, 1, 0, 0);
    checks++; if (o_wr_req !== 1'b0) begin errors++; $display("FAIL bp_req_drop: got %b want 0", o_wr_req); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b want 1", o_ready); end
    step(1, 4'd8, 0, 0, 0);
    checks++; if (o_wr_req !== 1'b1) begin errors++; $display("FAIL bp_req1: got %b want 1", o_wr_req); end
    checks++; if (o_sram_data !== 16'h8765) begin errors++; $display("FAIL bp_data1: got %h want 8765", o_sram_data); end
    checks++; if (o_sram_addr !== 20'd1) begin errors++; $display("FAIL bp_addr1: got %0d want 1", o_sram_addr); end
  endtask

  task automatic test_wrap();
    logic [19:0] seen[$];
    bit          last_granted;
    int          done_cnt;
    done_cnt = 0;
    do_reset();
    for (int n = 0; n < 15; n++) begin
      last_granted = w_wr_req && (w_sram_addr == 20'd17);
      if (w_wr_req) seen.push_back(w_sram_addr);
      step(n < 12, 4'(n + 1), 1, 0, 0);
      if (w_frame_done) done_cnt++;
      checks++; if (w_frame_done !== last_granted) begin errors++; $display("FAIL wrap_done_cycle%0d: got %b want %b", n, w_frame_done, last_granted); end
    end
    checks++; if (seen.size() != 3) begin errors++; $display("FAIL wrap_writes: got %0d writes want 3", seen.size()); end
    else begin
      checks++; if (seen[0] !== 20'd16 || seen[1] !== 20'd17 || seen[2] !== 20'd16) begin
        errors++; $display("FAIL wrap_addrs: got %0d,%0d,%0d want 16,17,16", seen[0], seen[1], seen[2]);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_frame_start();
    do_reset();
    step(1, 4'hA, 0, 0, 0);
    step(1, 4'hB, 0, 0, 0);
    step(1, 4'hC, 0, 1, 0);
    step(1, 4'hD, 0, 0, 0);
    step(1, 4'hE, 0, 0, 0);
    checks++; if (o_wr_req !== 1'b0) begin errors++; $display("FAIL fs_early_req: got %b want 0", o_wr_req); end
    step(1, 4'hF, 0, 0, 0);
    checks++; if (o_wr_req !== 1'b1) begin errors++; $display("FAIL fs_req: got %b want 1", o_wr_req); end
    checks++; if (o_sram_data !== 16'hFEDC) begin errors++; $display("FAIL fs_data: got %h want FEDC", o_sram_data); end
    checks++; if (o_sram_addr !== 20'd0) begin errors++; $display("FAIL fs_addr: got %0d want 0", o_sram_addr); end
    step(0, 4'h0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) step(1, 4'(i), 0, 0, 0);
    checks++; if (o_sram_addr !== 20'd1) begin errors++; $display("FAIL fs_addr_adv: got %0d want 1", o_sram_addr); end
    step(0, 4'h0, 1, 1, 0);
    checks++; if (o_wr_req !== 1'b0) begin errors++; $display("FAIL fs_drop_req: got %b want 0", o_wr_req); end
    checks++; if (o_sram_addr !== 20'd0) begin errors++; $display("FAIL fs_drop_addr: got %0d want 0", o_sram_addr); end
  endtask

  task automatic test_flush();
    do_reset();
    step(1, 4'hA, 0, 0, 0);
    step(1, 4'hB, 0, 0, 0);
    step(0, 4'h0, 0, 0, 1);
`ifdef SRAM_DATA_ENCODER_FLUSH_EN
    checks++; if (o_wr_req !== 1'b1) begin errors++; $display("FAIL flush_req: got %b want 1", o_wr_req); end
    checks++; if (o_sram_data !== 16'h00BA) begin errors++; $display("FAIL flush_data: got %h want 00BA", o_sram_data); end
    for (int i = 1; i <= 4; i++) step(1, 4'(i), 1, 0, 0);
    checks++; if (o_sram_data !== 16'h4321 || o_sram_addr !== 20'd1) begin
      errors++; $display("FAIL flush_next: got %h@%0d want 4321@1", o_sram_data, o_sram_addr);
    end
`else
    step(0, 4'h0, 1, 0, 0);
    checks++; if (o_wr_req !== 1'b0) begin errors++; $display("FAIL flush_ignored: got %b want 0", o_wr_req); end
    step(1, 4'hC, 0, 0, 0);
    step(1, 4'hD, 0, 0, 0);
    checks++; if (o_wr_req !== 1'b1 || o_sram_data !== 16'hDCBA) begin
      errors++; $display("FAIL flush_keep_partial: got req=%b data=%h want req=1 data=DCBA", o_wr_req, o_sram_data);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 1; i <= 6; i++) step(1, 4'(i), 0, 0, 0);
    do_reset();
    checks++; if (o_wr_req !== 1'b0) begin errors++; $display("FAIL rstmid_req: got %b want 0", o_wr_req); end
    checks++; if (o_sram_addr !== 20'd0) begin errors++; $display("FAIL rstmid_addr: got %0d want 0", o_sram_addr); end
    for (int i = 9; i <= 12; i++) step(1, 4'(i), 0, 0, 0);
    checks++; if (o_sram_data !== 16'hCBA9 || o_sram_addr !== 20'd0) begin
      errors++; $display("FAIL rstmid_word: got %h@%0d want CBA9@0", o_sram_data, o_sram_addr);
    end
  endtask

  task automatic test_random();
    bit v, g, fs, fl;
    logic [3:0] c;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      c  = 4'($urandom);
      g  = 1'($urandom_range(0, 1));
      fs = ($urandom_range(0, 63) == 0);
      fl = ($urandom_range(0, 15) == 0);
      step(v, c, g, fs, fl);
      checks++; if (o_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", n, o_ready, m_ready()); end
      checks++; if (o_wr_req !== m_pend) begin errors++; $display("FAIL rnd_req@%0d: got %b want %b", n, o_wr_req, m_pend); end
      checks++; if (o_sram_addr !== 20'(m_addr)) begin errors++; $display("FAIL rnd_addr@%0d: got %0d want %0d", n, o_sram_addr, m_addr); end
      checks++; if (o_frame_done !== m_fd) begin errors++; $display("FAIL rnd_done@%0d: got %b want %b", n, o_frame_done, m_fd); end
      if (m_pend) begin
        checks++; if (o_sram_data !== m_data) begin errors++; $display("FAIL rnd_data@%0d: got %h want %h", n, o_sram_data, m_data); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_pack();
    test_backpressure();
    test_wrap();
    test_frame_start();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
